// File: rtl/sp_cmd_dispatch.sv
// SP custom-instruction dispatcher: decodes func7, pulses one unit command, returns that unit's result.
// Optional WAIT-state timeout is compiled in when SP_DISPATCH_TIMEOUT_EN is defined.
module sp_cmd_dispatch #(
    parameter int  DATA_W               = 32,
    parameter int  TIMEOUT_CYCLES       = 1024,
    localparam int SP_UNIT_RX_NCMDS     = 6,
    localparam int SP_UNIT_TX_NCMDS     = 7,
    localparam int SP_UNIT_COMMON_NCMDS = 3,
    localparam int SP_UNIT_ACP_NCMDS    = 6
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [4:0]                      req_func7,
    input  logic [DATA_W-1:0]               req_rs1,
    input  logic [DATA_W-1:0]               req_rs2,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_W-1:0]               rsp_data,
    output logic                            rsp_err,
    output logic [DATA_W-1:0]               op1,
    output logic [DATA_W-1:0]               op2,
    output logic [SP_UNIT_RX_NCMDS-1:0]     rx_cmd,
    output logic [SP_UNIT_TX_NCMDS-1:0]     tx_cmd,
    output logic [SP_UNIT_COMMON_NCMDS-1:0] common_cmd,
    output logic [SP_UNIT_ACP_NCMDS-1:0]    acp_cmd,
    input  logic                            rx_done,
    input  logic [DATA_W-1:0]               rx_result,
    input  logic                            tx_done,
    input  logic [DATA_W-1:0]               tx_result,
    input  logic                            common_done,
    input  logic [DATA_W-1:0]               common_result,
    input  logic                            acp_done,
    input  logic [DATA_W-1:0]               acp_result,
    output logic                            busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
    typedef enum logic [1:0] {UNIT_RX, UNIT_TX, UNIT_COMMON, UNIT_ACP} unit_e;

    localparam logic [SP_UNIT_RX_NCMDS-1:0]     RX_ONE     = {{(SP_UNIT_RX_NCMDS-1){1'b0}}, 1'b1};
    localparam logic [SP_UNIT_TX_NCMDS-1:0]     TX_ONE     = {{(SP_UNIT_TX_NCMDS-1){1'b0}}, 1'b1};
    localparam logic [SP_UNIT_COMMON_NCMDS-1:0] COMMON_ONE = {{(SP_UNIT_COMMON_NCMDS-1){1'b0}}, 1'b1};
    localparam logic [SP_UNIT_ACP_NCMDS-1:0]    ACP_ONE    = {{(SP_UNIT_ACP_NCMDS-1){1'b0}}, 1'b1};

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("sp_cmd_dispatch: TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_q, state_d;
    unit_e             unit_q, unit_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic              dec_legal;
    logic [2:0]        dec_idx;
    logic              sel_done;
    logic [DATA_W-1:0] sel_result;

`ifdef SP_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_hit;

    // Counter holds the number of WAIT cycles already spent; the last allowed one times out.
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // RX and TX skip code 3 of their octet, so codes above it shift down by one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        dec_legal = 1'b0;
        dec_idx   = req_func7[2:0];
        case (req_func7[4:3])
            2'b00: begin
                dec_legal = (req_func7[2:0] != 3'd3) && (req_func7[2:0] != 3'd7);
                dec_idx   = (req_func7[2:0] > 3'd3) ? req_func7[2:0] - 3'd1 : req_func7[2:0];
            end
            2'b01: begin
                dec_legal = (req_func7[2:0] != 3'd3);
                dec_idx   = (req_func7[2:0] > 3'd3) ? req_func7[2:0] - 3'd1 : req_func7[2:0];
            end
            2'b10:   dec_legal = (req_func7[2:0] < 3'd3);
            default: dec_legal = (req_func7[2:0] < 3'd6);
        endcase
    end

    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        case (unit_q)
            UNIT_RX:     begin sel_done = rx_done;     sel_result = rx_result;     end
            UNIT_TX:     begin sel_done = tx_done;     sel_result = tx_result;     end
            UNIT_COMMON: begin sel_done = common_done; sel_result = common_result; end
            default:     begin sel_done = acp_done;    sel_result = acp_result;    end
        endcase
    end

    always_comb begin
        rx_cmd     = '0;
        tx_cmd     = '0;
        common_cmd = '0;
        acp_cmd    = '0;
        if (state_q == S_ISSUE) begin
            case (unit_q)
                UNIT_RX:     rx_cmd     = RX_ONE << idx_q;
                UNIT_TX:     tx_cmd     = TX_ONE << idx_q;
                UNIT_COMMON: common_cmd = COMMON_ONE << idx_q;
                default:     acp_cmd    = ACP_ONE << idx_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        unit_d     = unit_q;
        idx_d      = idx_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef SP_DISPATCH_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    unit_d = unit_e'(req_func7[4:3]);
                    idx_d  = dec_idx;
                    op1_d  = req_rs1;
                    op2_d  = req_rs2;
                    if (dec_legal) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d    = S_RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef SP_DISPATCH_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (sel_done) begin
                    state_d    = S_RESP;
                    rsp_data_d = sel_result;
                    rsp_err_d  = 1'b0;
                end
`ifdef SP_DISPATCH_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d    = S_RESP;
                    rsp_data_d = '1;
                    rsp_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            state_q    <= S_IDLE;
            unit_q     <= UNIT_RX;
            idx_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef SP_DISPATCH_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            unit_q     <= unit_d;
            idx_q      <= idx_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef SP_DISPATCH_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign op1       = op1_q;
    assign op2       = op2_q;

endmodule
